// File: rtl/atm_ctrl_param_if.sv
// Handshake and status bundle for the parameterised ATM controller.
// The controller takes the slave side; the host or bench drives the master side.
interface atm_ctrl_param_if #(
    parameter int N_ACCT = 16,
    parameter int CARD_W = 8,
    parameter int PIN_W  = 4,
    parameter int BAL_W  = 12
);
    localparam int IW = $clog2(N_ACCT);

    logic              prog_we;
    logic [IW-1:0]     prog_idx;
    logic [CARD_W-1:0] prog_card;
    logic [PIN_W-1:0]  prog_pin;
    logic [BAL_W-1:0]  prog_bal;
    logic              card_vld;
    logic [CARD_W-1:0] card_in;
    logic              pin_vld;
    logic [PIN_W-1:0]  pin_in;
    logic              op_vld;
    logic [1:0]        op;
    logic [BAL_W-1:0]  amount;
    logic [2:0]        state;
    logic [BAL_W-1:0]  bal_out;
    logic              done;
    logic              err;
    logic [2:0]        err_code;
    logic [IW-1:0]     acct_idx;
    logic              locked;

    modport slave (
        input  prog_we, prog_idx, prog_card, prog_pin, prog_bal,
        input  card_vld, card_in, pin_vld, pin_in,
        input  op_vld, op, amount,
        output state, bal_out, done, err, err_code, acct_idx, locked
    );

    modport master (
        output prog_we, prog_idx, prog_card, prog_pin, prog_bal,
        output card_vld, card_in, pin_vld, pin_in,
        output op_vld, op, amount,
        input  state, bal_out, done, err, err_code, acct_idx, locked
    );
endinterface

// File: rtl/atm_ctrl_param.sv
// ATM session controller: account table, linear card scan, PIN check with
// lockout, deposit/withdraw/balance execution and inactivity timeout.
module atm_ctrl_param #(
    parameter int N_ACCT    = 16,
    parameter int CARD_W    = 8,
    parameter int PIN_W     = 4,
    parameter int BAL_W     = 12,
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 1000,
    parameter int LOCK_CYC  = 500
) (
    input logic clk,
    input logic rst,
    atm_ctrl_param_if.slave bus
);
    localparam int IW  = $clog2(N_ACCT);
    localparam int TRW = $clog2(MAX_TRIES + 1);
    localparam int TMW = $clog2(TIMEOUT + 1);
    localparam int LKW = $clog2(LOCK_CYC + 1);

    localparam logic [2:0] E_NOCARD  = 3'd1;
    localparam logic [2:0] E_BADPIN  = 3'd2;
    localparam logic [2:0] E_LOCKED  = 3'd3;
    localparam logic [2:0] E_OVF     = 3'd4;
    localparam logic [2:0] E_NSF     = 3'd5;
    localparam logic [2:0] E_TIMEOUT = 3'd6;

    localparam logic [1:0] OP_EXIT = 2'b00;
    localparam logic [1:0] OP_DEP  = 2'b01;
    localparam logic [1:0] OP_WD   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_PIN  = 3'd2,
        S_MENU = 3'd3,
        S_EXEC = 3'd4,
        S_LOCK = 3'd5
    } state_e;

    state_e            state_q;
    logic [N_ACCT-1:0] vld_q;
    logic [CARD_W-1:0] card_mem [N_ACCT];
    logic [PIN_W-1:0]  pin_mem  [N_ACCT];
    logic [BAL_W-1:0]  bal_mem  [N_ACCT];
    logic [CARD_W-1:0] card_q;
    logic [IW-1:0]     scan_q;
    logic [IW-1:0]     acct_q;
    logic [TRW-1:0]    tries_q;
    logic [TMW-1:0]    tmr_q;
    logic [LKW-1:0]    lck_q;
    logic [1:0]        op_q;
    logic [BAL_W-1:0]  amt_q;
    logic [BAL_W-1:0]  bal_q;
    logic              done_q;
    logic              err_q;
    logic [2:0]        ec_q;

    logic [BAL_W-1:0]  cur_bal;
    logic [BAL_W:0]    sum_d;
    logic              ovf_d;
    logic              nsf_d;
    logic [BAL_W-1:0]  new_bal_d;
    logic              wr_prog;
    logic              wr_exec;
    logic              tmo_d;

    // Deposit sum is one bit wider so overflow is just the carry-out.
    always_comb begin
        cur_bal   = bal_mem[acct_q];
        sum_d     = {1'b0, cur_bal} + {1'b0, amt_q};
        ovf_d     = sum_d[BAL_W];
        nsf_d     = amt_q > cur_bal;
        new_bal_d = (op_q == OP_DEP) ? sum_d[BAL_W-1:0] : cur_bal - amt_q;
        wr_prog   = (state_q == S_IDLE) && bus.prog_we;
        wr_exec   = (state_q == S_EXEC) &&
                    (((op_q == OP_DEP) && !ovf_d) ||
                     ((op_q == OP_WD) && !nsf_d));
        tmo_d     = tmr_q == TMW'(TIMEOUT - 1);
    end

    // Table data needs no reset; slot visibility is governed by vld_q.
    always_ff @(posedge clk) begin
        if (rst && wr_prog) begin
            card_mem[bus.prog_idx] <= bus.prog_card;
            pin_mem[bus.prog_idx]  <= bus.prog_pin;
            bal_mem[bus.prog_idx]  <= bus.prog_bal;
        end else if (rst && wr_exec) begin
            bal_mem[acct_q] <= new_bal_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            vld_q   <= '0;
            card_q  <= '0;
            scan_q  <= '0;
            acct_q  <= '0;
            tries_q <= '0;
            tmr_q   <= '0;
            lck_q   <= '0;
            op_q    <= '0;
            amt_q   <= '0;
            bal_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ec_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.prog_we) begin
                        vld_q[bus.prog_idx] <= 1'b1;
                    end else if (bus.card_vld) begin
                        card_q  <= bus.card_in;
                        scan_q  <= '0;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (vld_q[scan_q] && (card_mem[scan_q] == card_q)) begin
                        acct_q  <= scan_q;
                        tmr_q   <= '0;
                        state_q <= S_PIN;
                    end else if (scan_q == IW'(N_ACCT - 1)) begin
                        err_q   <= 1'b1;
                        ec_q    <= E_NOCARD;
                        state_q <= S_IDLE;
                    end else begin
                        scan_q <= scan_q + 1'b1;
                    end
                end
                S_PIN: begin
                    tmr_q <= tmr_q + 1'b1;
                    if (bus.pin_vld) begin
                        tmr_q <= '0;
                        if (bus.pin_in == pin_mem[acct_q]) begin
                            tries_q <= '0;
                            state_q <= S_MENU;
                        end else if (tries_q == TRW'(MAX_TRIES - 1)) begin
                            err_q   <= 1'b1;
                            ec_q    <= E_LOCKED;
                            lck_q   <= '0;
                            state_q <= S_LOCK;
                        end else begin
                            tries_q <= tries_q + 1'b1;
                            err_q   <= 1'b1;
                            ec_q    <= E_BADPIN;
                        end
                    end else if (tmo_d) begin
                        tries_q <= '0;
                        err_q   <= 1'b1;
                        ec_q    <= E_TIMEOUT;
                        state_q <= S_IDLE;
                    end
                end
                S_MENU: begin
                    tmr_q <= tmr_q + 1'b1;
                    if (bus.op_vld) begin
                        tmr_q <= '0;
                        if (bus.op == OP_EXIT) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            op_q    <= bus.op;
                            amt_q   <= bus.amount;
                            state_q <= S_EXEC;
                        end
                    end else if (tmo_d) begin
                        err_q   <= 1'b1;
                        ec_q    <= E_TIMEOUT;
                        state_q <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    tmr_q   <= '0;
                    state_q <= S_MENU;
                    if ((op_q == OP_DEP) && ovf_d) begin
                        err_q <= 1'b1;
                        ec_q  <= E_OVF;
                        bal_q <= cur_bal;
                    end else if ((op_q == OP_WD) && nsf_d) begin
                        err_q <= 1'b1;
                        ec_q  <= E_NSF;
                        bal_q <= cur_bal;
                    end else if (wr_exec) begin
                        done_q <= 1'b1;
                        bal_q  <= new_bal_d;
                    end else begin
                        done_q <= 1'b1;
                        bal_q  <= cur_bal;
                    end
                end
                S_LOCK: begin
                    if (lck_q == LKW'(LOCK_CYC - 1)) begin
                        tries_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        lck_q <= lck_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.state    = state_q;
    assign bus.bal_out  = bal_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_code = ec_q;
    assign bus.acct_idx = acct_q;
    assign bus.locked   = (state_q == S_LOCK);
endmodule
